// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: drives the PC register, fetches over a req/ack port
// and feeds IF/ID through a one-entry stallable output register.
module fetch_unit #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    output logic        pc_write_o,
    output logic [31:0] pc_next_o,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    input  logic        stall_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        err_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERR} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [31:0] r_hold_inst;
    logic [31:0] r_hold_pc;
    logic [31:0] r_drop_addr;
    logic        r_valid;
    logic        r_err;
    logic        r_drop;
    logic [7:0]  r_wait;

    logic        w_free;
    logic        w_ack;
    logic        w_branch;
    logic        w_timeout;
    logic [31:0] w_pc_inc;

    assign w_pc_inc  = pc_i + 32'd4;
    assign w_free    = !r_valid || !stall_i;
    assign w_ack     = (r_state == S_REQ) && mem_ack_i;
    assign w_branch  = branch_i && (r_state != S_ERR) && !rst_i;
    assign w_timeout = (r_state == S_REQ) && !mem_ack_i && (r_wait == WAIT_LAST);

    // A dropped request keeps its original address; the PC already holds the target.
    assign mem_req_o    = (r_state == S_REQ);
    assign mem_addr_o   = r_drop ? r_drop_addr : pc_i;
    assign pc_write_o   = w_branch || (w_ack && !r_drop && !rst_i);
    assign pc_next_o    = w_branch ? branch_target_i : w_pc_inc;
    assign inst_o       = r_inst;
    assign inst_pc_o    = r_inst_pc;
    assign inst_valid_o = r_valid;
    assign err_o        = r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_inst      <= 32'd0;
            r_inst_pc   <= 32'd0;
            r_hold_inst <= 32'd0;
            r_hold_pc   <= 32'd0;
            r_drop_addr <= 32'd0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_drop      <= 1'b0;
            r_wait      <= 8'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_wait  <= 8'd0;
                    if (w_branch || (r_valid && !stall_i))
                        r_valid <= 1'b0;
                end
                S_REQ: begin
                    if (mem_ack_i)
                        r_wait <= 8'd0;
                    else if (!w_timeout)
                        r_wait <= r_wait + 8'd1;

                    if (w_timeout) begin
                        r_state <= S_ERR;
                        r_err   <= 1'b1;
                        r_valid <= 1'b0;
                        r_drop  <= 1'b0;
                    end else if (w_branch) begin
                        r_valid <= 1'b0;
                        if (mem_ack_i) begin
                            r_drop <= 1'b0;
                        end else begin
                            r_drop <= 1'b1;
                            if (!r_drop)
                                r_drop_addr <= pc_i;
                        end
                    end else if (mem_ack_i) begin
                        if (r_drop) begin
                            r_drop <= 1'b0;
                            if (r_valid && !stall_i)
                                r_valid <= 1'b0;
                        end else if (w_free) begin
                            r_inst    <= mem_data_i;
                            r_inst_pc <= pc_i;
                            r_valid   <= 1'b1;
                        end else begin
                            r_hold_inst <= mem_data_i;
                            r_hold_pc   <= pc_i;
                            r_state     <= S_HOLD;
                        end
                    end else if (r_valid && !stall_i) begin
                        r_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_branch) begin
                        r_valid <= 1'b0;
                        r_state <= S_REQ;
                        r_wait  <= 8'd0;
                    end else if (w_free) begin
                        r_inst    <= r_hold_inst;
                        r_inst_pc <= r_hold_pc;
                        r_valid   <= 1'b1;
                        r_state   <= S_REQ;
                        r_wait    <= 8'd0;
                    end
                end
                S_ERR: begin
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a PC register and variable-latency memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_i;
    logic [31:0] pc;
    logic        pc_write_o;
    logic [31:0] pc_next_o;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        stall_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        err_o;

    int passed = 0;
    int total  = 0;

    // memory model state and per-cycle samples taken just before each edge
    bit          mem_on;
    int          mem_lat;
    int          mem_cnt;
    logic        s_pw;
    logic        s_req;
    logic        s_ack;
    logic [31:0] s_pn;
    logic [31:0] s_addr;

    fetch_unit #(.MAX_WAIT(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .pc_i            (pc),
        .pc_write_o      (pc_write_o),
        .pc_next_o       (pc_next_o),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ack_i       (mem_ack_i),
        .mem_data_i      (mem_data_i),
        .stall_i         (stall_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_valid_o    (inst_valid_o),
        .err_o           (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock: memory responds, outputs are sampled, edge, then PC register updates.
    task automatic step();
        #1;
        if (mem_on && mem_req_o && (mem_cnt >= mem_lat)) begin
            mem_ack_i  = 1'b1;
            mem_data_i = 32'h1000_0000 + mem_addr_o;
        end else begin
            mem_ack_i  = 1'b0;
            mem_data_i = 32'hDEAD_BEEF;
        end
        #1;
        s_pw   = pc_write_o;
        s_pn   = pc_next_o;
        s_req  = mem_req_o;
        s_addr = mem_addr_o;
        s_ack  = mem_ack_i;
        @(posedge clk);
        #1;
        if (s_pw) pc = s_pn;
        if (s_req) mem_cnt = s_ack ? 0 : mem_cnt + 1;
        mem_ack_i = 1'b0;
    endtask

    // Leaves the DUT at the start of its first S_REQ cycle; s_* hold the S_IDLE cycle.
    task automatic do_reset(input logic [31:0] start);
        rst_i     = 1'b1;
        branch_i  = 1'b0;
        stall_i   = 1'b0;
        mem_ack_i = 1'b0;
        step();
        pc      = start;
        mem_cnt = 0;
        rst_i   = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_i = 1'b1; pc = 32'h0; stall_i = 1'b0; mem_ack_i = 1'b0;
        mem_data_i = 32'h0; branch_i = 1'b1; branch_target_i = 32'h100;
        #1;
        total++; if (mem_req_o !== 1'b0) $display("FAIL rst_req got %b want 0", mem_req_o); else passed++;
        total++; if (pc_write_o !== 1'b0) $display("FAIL rst_pw got %b want 0", pc_write_o); else passed++;
        total++; if (inst_valid_o !== 1'b0) $display("FAIL rst_valid got %b want 0", inst_valid_o); else passed++;
        total++; if (err_o !== 1'b0) $display("FAIL rst_err got %b want 0", err_o); else passed++;
        total++; if (inst_o !== 32'h0) $display("FAIL rst_inst got %h want 0", inst_o); else passed++;
        total++; if (inst_pc_o !== 32'h0) $display("FAIL rst_inst_pc got %h want 0", inst_pc_o); else passed++;
        branch_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        mem_on = 1'b1; mem_lat = 0;
        do_reset(32'h0);
        total++; if (s_pw !== 1'b0) $display("FAIL b2b_idle_pw got %b want 0", s_pw); else passed++;
        total++; if (s_req !== 1'b0) $display("FAIL b2b_idle_req got %b want 0", s_req); else passed++;
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (s_pw !== 1'b1) $display("FAIL b2b_pw%0d got %b want 1", k, s_pw); else passed++;
            total++; if (s_addr !== 32'(4*k)) $display("FAIL b2b_addr%0d got %h want %h", k, s_addr, 32'(4*k)); else passed++;
            total++; if (inst_pc_o !== 32'(4*k)) $display("FAIL b2b_ipc%0d got %h want %h", k, inst_pc_o, 32'(4*k)); else passed++;
            total++; if (inst_o !== 32'h1000_0000 + 32'(4*k)) $display("FAIL b2b_inst%0d got %h want %h", k, inst_o, 32'h1000_0000 + 32'(4*k)); else passed++;
            total++; if (inst_valid_o !== 1'b1) $display("FAIL b2b_valid%0d got %b want 1", k, inst_valid_o); else passed++;
        end
    endtask

    task automatic test_slow_mem();
        mem_on = 1'b1; mem_lat = 3;
        do_reset(32'h40);
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (s_addr !== 32'h40) $display("FAIL slow_addr%0d got %h want 40", k, s_addr); else passed++;
            total++; if (s_pw !== (k == 3)) $display("FAIL slow_pw%0d got %b want %b", k, s_pw, (k == 3)); else passed++;
        end
        total++; if (s_pn !== 32'h44) $display("FAIL slow_pn got %h want 44", s_pn); else passed++;
        total++; if (inst_pc_o !== 32'h40) $display("FAIL slow_ipc got %h want 40", inst_pc_o); else passed++;
        total++; if (inst_o !== 32'h1000_0040) $display("FAIL slow_inst got %h want 10000040", inst_o); else passed++;
        total++; if (inst_valid_o !== 1'b1) $display("FAIL slow_valid got %b want 1", inst_valid_o); else passed++;
        total++; if (err_o !== 1'b0) $display("FAIL slow_err got %b want 0", err_o); else passed++;
        step();
        total++; if (s_addr !== 32'h44) $display("FAIL slow_next_addr got %h want 44", s_addr); else passed++;
    endtask

    task automatic test_stall_hold();
        mem_on = 1'b1; mem_lat = 0;
        do_reset(32'h0);
        step();
        step();
        stall_i = 1'b1;
        step();
        total++; if (s_addr !== 32'h8) $display("FAIL hold_addr got %h want 8", s_addr); else passed++;
        total++; if (s_pw !== 1'b1 || s_pn !== 32'hC) $display("FAIL hold_pw got %b/%h want 1/c", s_pw, s_pn); else passed++;
        total++; if (mem_req_o !== 1'b0) $display("FAIL hold_req got %b want 0", mem_req_o); else passed++;
        total++; if (inst_pc_o !== 32'h4 || inst_valid_o !== 1'b1) $display("FAIL hold_out got %h/%b want 4/1", inst_pc_o, inst_valid_o); else passed++;
        step();
        total++; if (s_req !== 1'b0 || s_pw !== 1'b0) $display("FAIL hold_idle got req %b pw %b want 0 0", s_req, s_pw); else passed++;
        total++; if (inst_pc_o !== 32'h4) $display("FAIL hold_keep got %h want 4", inst_pc_o); else passed++;
        stall_i = 1'b0;
        step();
        total++; if (s_req !== 1'b0) $display("FAIL hold_rel_req got %b want 0", s_req); else passed++;
        total++; if (inst_pc_o !== 32'h8 || inst_o !== 32'h1000_0008) $display("FAIL hold_rel_out got %h/%h want 8/10000008", inst_pc_o, inst_o); else passed++;
        total++; if (inst_valid_o !== 1'b1) $display("FAIL hold_rel_valid got %b want 1", inst_valid_o); else passed++;
        total++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'hC) $display("FAIL hold_rel_req_c got %b/%h want 1/c", mem_req_o, mem_addr_o); else passed++;
        step();
        total++; if (inst_pc_o !== 32'hC) $display("FAIL hold_next got %h want c", inst_pc_o); else passed++;
    endtask

    task automatic test_branch_drop();
        mem_on = 1'b1; mem_lat = 2;
        do_reset(32'h10);
        branch_i = 1'b1; branch_target_i = 32'h200;
        step();
        branch_i = 1'b0;
        total++; if (s_pw !== 1'b1 || s_pn !== 32'h200) $display("FAIL drop_br_pw got %b/%h want 1/200", s_pw, s_pn); else passed++;
        total++; if (s_addr !== 32'h10) $display("FAIL drop_br_addr got %h want 10", s_addr); else passed++;
        step();
        total++; if (s_addr !== 32'h10 || s_pw !== 1'b0) $display("FAIL drop_wait got %h/%b want 10/0", s_addr, s_pw); else passed++;
        step();
        total++; if (s_ack !== 1'b1 || s_addr !== 32'h10) $display("FAIL drop_ack got %b/%h want 1/10", s_ack, s_addr); else passed++;
        total++; if (s_pw !== 1'b0) $display("FAIL drop_ack_pw got %b want 0", s_pw); else passed++;
        total++; if (inst_valid_o !== 1'b0) $display("FAIL drop_valid got %b want 0", inst_valid_o); else passed++;
        step();
        total++; if (s_addr !== 32'h200) $display("FAIL drop_resume_addr got %h want 200", s_addr); else passed++;
        step();
        step();
        total++; if (s_pw !== 1'b1 || s_pn !== 32'h204) $display("FAIL drop_tgt_pw got %b/%h want 1/204", s_pw, s_pn); else passed++;
        total++; if (inst_pc_o !== 32'h200 || inst_o !== 32'h1000_0200) $display("FAIL drop_tgt_out got %h/%h want 200/10000200", inst_pc_o, inst_o); else passed++;
        total++; if (inst_valid_o !== 1'b1) $display("FAIL drop_tgt_valid got %b want 1", inst_valid_o); else passed++;
    endtask

    task automatic test_branch_ack();
        mem_on = 1'b1; mem_lat = 0;
        do_reset(32'h0);
        step();
        branch_i = 1'b1; branch_target_i = 32'h80;
        step();
        branch_i = 1'b0;
        total++; if (s_ack !== 1'b1 || s_pw !== 1'b1 || s_pn !== 32'h80) $display("FAIL bra_pw got ack %b pw %b pn %h want 1 1 80", s_ack, s_pw, s_pn); else passed++;
        total++; if (inst_valid_o !== 1'b0 || inst_pc_o !== 32'h0) $display("FAIL bra_out got %b/%h want 0/0", inst_valid_o, inst_pc_o); else passed++;
        step();
        total++; if (s_addr !== 32'h80 || inst_pc_o !== 32'h80 || inst_valid_o !== 1'b1) $display("FAIL bra_tgt got %h/%h/%b want 80/80/1", s_addr, inst_pc_o, inst_valid_o); else passed++;
    endtask

    task automatic test_timeout();
        mem_on = 1'b0; mem_lat = 0;
        do_reset(32'h20);
        step(); step(); step();
        total++; if (err_o !== 1'b0 || mem_req_o !== 1'b1) $display("FAIL to_early got err %b req %b want 0 1", err_o, mem_req_o); else passed++;
        step();
        total++; if (err_o !== 1'b1) $display("FAIL to_err got %b want 1", err_o); else passed++;
        total++; if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) $display("FAIL to_outs got req %b valid %b want 0 0", mem_req_o, inst_valid_o); else passed++;
        branch_i = 1'b1; branch_target_i = 32'h300;
        step();
        branch_i = 1'b0;
        total++; if (s_pw !== 1'b0 || pc !== 32'h20) $display("FAIL to_branch got pw %b pc %h want 0 20", s_pw, pc); else passed++;
        total++; if (err_o !== 1'b1 || mem_req_o !== 1'b0) $display("FAIL to_sticky got err %b req %b want 1 0", err_o, mem_req_o); else passed++;
        rst_i = 1'b1;
        #1;
        total++; if (err_o !== 1'b0) $display("FAIL to_rst_err got %b want 0", err_o); else passed++;
        step();
    endtask

    task automatic test_async_reset();
        mem_on = 1'b1; mem_lat = 0;
        do_reset(32'h0);
        step();
        step();
        mem_ack_i = 1'b1; mem_data_i = 32'h1000_0008;
        branch_i = 1'b1; branch_target_i = 32'h400;
        #1;
        total++; if (pc_write_o !== 1'b1 || mem_req_o !== 1'b1 || inst_valid_o !== 1'b1) $display("FAIL ar_pre got pw %b req %b valid %b want 1 1 1", pc_write_o, mem_req_o, inst_valid_o); else passed++;
        rst_i = 1'b1;
        #1;
        total++; if (mem_req_o !== 1'b0) $display("FAIL ar_req got %b want 0", mem_req_o); else passed++;
        total++; if (inst_valid_o !== 1'b0) $display("FAIL ar_valid got %b want 0", inst_valid_o); else passed++;
        total++; if (pc_write_o !== 1'b0) $display("FAIL ar_pw got %b want 0", pc_write_o); else passed++;
        branch_i = 1'b0;
        mem_ack_i = 1'b0;
        step();
        mem_cnt = 0;
        rst_i = 1'b0;
        step();
        total++; if (s_req !== 1'b0) $display("FAIL ar_idle got %b want 0", s_req); else passed++;
        step();
        total++; if (s_addr !== 32'h8 || s_pw !== 1'b1) $display("FAIL ar_restart got %h/%b want 8/1", s_addr, s_pw); else passed++;
        total++; if (inst_pc_o !== 32'h8 || inst_valid_o !== 1'b1) $display("FAIL ar_out got %h/%b want 8/1", inst_pc_o, inst_valid_o); else passed++;
    endtask

    initial begin
        mem_on = 1'b0; mem_lat = 0; mem_cnt = 0;
        test_reset();
        test_back_to_back();
        test_slow_mem();
        test_stall_hold();
        test_branch_drop();
        test_branch_ack();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
